// File: rtl/lut_neuron_pkg.sv
// Shared types and defaults for the LUT neuron layer.
package lut_neuron_pkg;

  // Control FSM: tables are writable only in StConfig; StDrain empties the output stage first.
  typedef enum logic [1:0] {
    StConfig = 2'd0,
    StRun    = 2'd1,
    StDrain  = 2'd2
  } state_e;

  localparam int unsigned DefNNeurons = 4;
  localparam int unsigned DefFanIn    = 6;
  localparam int unsigned DefOutBits  = 1;

  // Width of the neuron select field; never narrower than one bit.
  function automatic int unsigned neuron_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_neuron_table.sv
// One neuron's truth table: 2^FAN_IN x OUT_BITS registers, one write port, async read.
module lut_neuron_table import lut_neuron_pkg::*; #(
  parameter int unsigned FAN_IN   = DefFanIn,
  parameter int unsigned OUT_BITS = DefOutBits
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [FAN_IN-1:0]   waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [FAN_IN-1:0]   raddr,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int unsigned Depth = 1 << FAN_IN;

  logic [OUT_BITS-1:0] mem_q [Depth];

  // Table storage; reset clears every entry so a fresh layer computes all-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Lookup is a plain mux; the registered stage lives in the layer top.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/lut_neuron_layer.sv
// Registered layer of run-time-loadable LUT neurons with valid/ready streaming.
// Optional build macro LUT_STATUS_EN adds a saturating accepted-beat counter output.
module lut_neuron_layer import lut_neuron_pkg::*; #(
  parameter int unsigned N_NEURONS = DefNNeurons,
  parameter int unsigned FAN_IN    = DefFanIn,
  parameter int unsigned OUT_BITS  = DefOutBits,
  localparam int unsigned NW       = neuron_idx_w(N_NEURONS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic                          cfg_we,
  input  logic [NW-1:0]                 cfg_neuron,
  input  logic [FAN_IN-1:0]             cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data,
  input  logic                          cfg_commit,
  output logic                          cfg_ready,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*FAN_IN-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data
`ifdef LUT_STATUS_EN
  ,
  output logic [15:0]                   lookup_count
`endif
);

  state_e state_q, state_d;

  logic                          out_valid_q, out_valid_d;
  logic [N_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
  logic [N_NEURONS*OUT_BITS-1:0] lookup;
  logic [N_NEURONS-1:0]          tbl_we;
  logic                          cfg_wr_en;
  logic                          in_accept;

  assign cfg_wr_en = (state_q == StConfig) && cfg_we;

  // Per-neuron tables; an out-of-range cfg_neuron matches no instance and is dropped.
  for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
    assign tbl_we[n] = cfg_wr_en && (cfg_neuron == NW'(n));

    lut_neuron_table #(
      .FAN_IN   (FAN_IN),
      .OUT_BITS (OUT_BITS)
    ) u_table (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (tbl_we[n]),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (in_data[n*FAN_IN +: FAN_IN]),
      .rdata (lookup[n*OUT_BITS +: OUT_BITS])
    );
  end

  // Handshake: accept only in StRun when the output stage is empty or being drained.
  always_comb begin
    cfg_ready = (state_q == StConfig);
    in_ready  = (state_q == StRun) && (!out_valid_q || out_ready);
    in_accept = in_valid && in_ready;
  end

  // Next-state: a beat accepted alongside cfg_start still lands in the output stage.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StConfig: if (cfg_commit) state_d = StRun;
      StRun:    if (cfg_start)  state_d = StDrain;
      StDrain:  if (!out_valid_q || out_ready) state_d = StConfig;
      default:  state_d = StConfig;
    endcase
  end

  // Output stage next-state: load on accept, clear on consume, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = lookup;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StConfig;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef LUT_STATUS_EN
  logic [15:0] count_q;
  logic        enter_config;

  assign enter_config = (state_d == StConfig) && (state_q != StConfig);

  // Saturating count of accepted beats, zeroed whenever the layer re-enters StConfig.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (enter_config) begin
      count_q <= '0;
    end else if (in_accept && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign lookup_count = count_q;
`endif

endmodule

// File: tb/tb_lut_neuron_layer.sv
// Directed bench for lut_neuron_layer with a queue scoreboard on the output stream.
module tb_lut_neuron_layer;

  localparam int N = 4;
  localparam int F = 6;
  localparam int O = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_start, cfg_we, cfg_commit;
  logic [1:0]     cfg_neuron;
  logic [F-1:0]   cfg_addr;
  logic [O-1:0]   cfg_data;
  logic           cfg_ready;
  logic           in_valid, in_ready;
  logic [N*F-1:0] in_data;
  logic           out_valid, out_ready;
  logic [N*O-1:0] out_data;
`ifdef LUT_STATUS_EN
  logic [15:0]    lookup_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [O-1:0]   tb_tab [N][1<<F];
  logic [N*O-1:0] sb_q [$];

  lut_neuron_layer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_we     (cfg_we),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_ready  (cfg_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef LUT_STATUS_EN
    ,
    .lookup_count (lookup_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*O-1:0] model(input logic [N*F-1:0] d);
    logic [N*O-1:0] r;
    for (int n = 0; n < N; n++) r[n*O +: O] = tb_tab[n][d[n*F +: F]];
    return r;
  endfunction

  task automatic model_clear();
    for (int n = 0; n < N; n++)
      for (int a = 0; a < (1 << F); a++) tb_tab[n][a] = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int n, input int a, input int d, input bit upd);
    cfg_we = 1'b1;
    cfg_neuron = 2'(n);
    cfg_addr = F'(a);
    cfg_data = O'(d);
    cyc();
    cfg_we = 1'b0;
    if (upd) tb_tab[n][a] = O'(d);
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
  endtask

  // Scoreboard: pop on each output handshake, push on each input handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          chk("sb_data", 32'(out_data), 32'(sb_q.pop_front()));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(in_data));
    end
  end

  initial begin
    logic [N*F-1:0] d1, d2;
    rst_n = 1'b0;
    cfg_start = 0; cfg_we = 0; cfg_commit = 0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
    in_valid = 0; in_data = '0; out_ready = 0;
    model_clear();

    // Reset state
    @(negedge clk);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();

    // Basic lookup
    cfg_write(0, 6'b101010, 1, 1'b1);
    cfg_write(3, 6'b111111, 1, 1'b1);
    commit();
    in_valid = 1'b1;
    in_data = {6'b111111, 6'b000000, 6'b000000, 6'b101010};
    @(negedge clk);
    chk("basic_in_ready", 32'(in_ready), 32'd1);
    chk("basic_cfg_ready_run", 32'(cfg_ready), 32'd0);
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("basic_out_valid", 32'(out_valid), 32'd1);
    chk("basic_out_data", 32'(out_data), 32'b1001);
    cyc();

    // Streaming 8 beats
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = (i % 2 == 0) ? {6'b111111, 12'd0, 6'b101010} : (N*F)'($urandom());
      @(negedge clk);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      if (i > 0) chk("stream_out_valid", 32'(out_valid), 32'd1);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", 32'(out_valid), 32'd1);
    cyc();
    @(negedge clk);
    chk("stream_idle_valid", 32'(out_valid), 32'd0);
    cyc();

    // Backpressure: output held stable, next beat waits
    d1 = {6'b111111, 12'd0, 6'b101010};
    d2 = {6'b111111, 12'd0, 6'b000001};
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = d1;
    cyc();
    in_data = d2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_data", 32'(out_data), 32'(model(d1)));
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("release_out_data", 32'(out_data), 32'b1000);
    cyc();

    // Drain with a held beat; cfg_we in RUN and DRAIN must be dropped
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = d1;
    cyc();
    in_valid = 1'b0;
    cfg_start = 1'b1;
    cfg_we = 1'b1; cfg_neuron = 2'd0; cfg_addr = '0; cfg_data = 1'b1;
    cyc();
    cfg_start = 1'b0;
    @(negedge clk);
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    chk("drain_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd1);
    cyc();
    cfg_we = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_wait_cfg_ready", 32'(cfg_ready), 32'd0);
    cyc();
    @(negedge clk);
    chk("drain_done_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("drain_done_out_valid", 32'(out_valid), 32'd0);
    chk("drain_done_in_ready", 32'(in_ready), 32'd0);
    cyc();

    // Write and commit in the same cycle
    cfg_we = 1'b1; cfg_neuron = 2'd1; cfg_addr = 6'd5; cfg_data = 1'b1;
    cfg_commit = 1'b1;
    cyc();
    tb_tab[1][5] = 1'b1;
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
    in_valid = 1'b1;
    in_data = {6'd0, 6'd0, 6'd5, 6'd0};
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("wrcommit_out_data", 32'(out_data), 32'b0010);
    cyc();

    // Asynchronous reset mid-stream with a held beat
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = d1;
    cyc();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    sb_q.delete();
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    commit();
    in_valid = 1'b1;
    in_data = d1;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_table_cleared", 32'(out_data), 32'd0);
    cyc();

`ifdef LUT_STATUS_EN
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = (N*F)'(i);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("count_5", 32'(lookup_count), 32'd6);
    cyc();
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    cyc();
    @(negedge clk);
    chk("count_cleared", 32'(lookup_count), 32'd0);
    commit();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = (N*F)'(i);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("count_exact_5", 32'(lookup_count), 32'd5);
    cyc();
    for (int i = 0; i < 65540; i++) begin
      in_valid = 1'b1;
      in_data = (N*F)'(i);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("count_saturated", 32'(lookup_count), 32'hFFFF);
    cyc();
`endif

    cyc();
    @(negedge clk);
    chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lut_neuron_layer.md
# lut_neuron_layer

- Parametrised, registered layer of LUT neurons with a run-time-loadable truth table per neuron.
- Generalises the fixed single-neuron 6-input combinational ROM to N neurons, configurable fan-in and output width.
- Adds a valid/ready streaming datapath and a configuration FSM that drains the pipeline before tables are rewritten.
- Sits between quantised feature registers and the next network layer.

## Interface
- N_NEURONS, 4, neurons in the layer
- FAN_IN, 6, input bits per neuron (table depth 2^FAN_IN)
- OUT_BITS, 1, output bits per neuron
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  pulse: request reconfiguration (honoured in RUN)
- cfg_we  in  1  table write strobe (honoured in CONFIG only)
- cfg_neuron  in  max(1,$clog2(N_NEURONS))  target neuron
- cfg_addr  in  FAN_IN  table entry index
- cfg_data  in  OUT_BITS  entry value
- cfg_commit  in  1  pulse: leave CONFIG, enter RUN
- cfg_ready  out  1  high in CONFIG
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_data  in  N_NEURONS*FAN_IN  neuron n address = in_data[n*FAN_IN +: FAN_IN]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  N_NEURONS*OUT_BITS  neuron n result = out_data[n*OUT_BITS +: OUT_BITS]

## Operation
- FSM states: CONFIG (reset state), RUN, DRAIN.
- CONFIG: cfg_ready=1, in_ready=0; cfg_we writes table[cfg_neuron][cfg_addr]=cfg_data; cfg_neuron >= N_NEURONS ignored; cfg_commit -> RUN. cfg_we and cfg_commit in same cycle: write performed, then RUN.
- RUN: in_ready = !out_valid || out_ready; accepted beat latches table[n][addr_n] for every n into out_data, sets out_valid. cfg_we ignored. cfg_start -> DRAIN; a beat accepted in the same cycle still completes.
- DRAIN: in_ready=0; -> CONFIG in the cycle out_valid is 0, or out_valid&&out_ready (entry into CONFIG next edge).
- out_valid clears on out_valid&&out_ready with no new beat; simultaneous accept-out and accept-in keeps out_valid=1 with new data.
- out_data held stable while out_valid&&!out_ready.
- cfg_start outside RUN, cfg_commit outside CONFIG: ignored.

## Timing
- Reset (async assert, sync release): state=CONFIG, all table entries 0, out_valid=0, out_data=0, cfg_ready=1 (combinational from state), in_ready=0.
- Lookup latency 1 cycle: accepted at edge k, out_valid/out_data at k+1.
- Throughput 1 beat/cycle under continuous out_ready.
- Table write visible to lookups from the next cycle; writes cannot overlap lookups (CONFIG only).
- Reset mid-stream discards any held beat and all table contents.

## Configuration
- LUT_STATUS_EN defined: adds output lookup_count[15:0]; increments on each accepted input beat, saturates at 16'hFFFF, reset 0, cleared on entry to CONFIG.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package lut_neuron_pkg: state enum (CONFIG, RUN, DRAIN), default parameter constants, cfg_neuron width function.
- Sub-module lut_neuron_table: one neuron's 2^FAN_IN x OUT_BITS register array, write port, combinational read mux; instantiated N_NEURONS times; FSM, handshake and output register in the top.

## Test plan
- Reset, probe -> cfg_ready=1, in_ready=0, out_valid=0, out_data=0.
- Defaults; write neuron0 addr 6'b101010=1, neuron3 addr 6'b111111=1, commit; send neuron0=6'b101010, neuron3=6'b111111, others 0 -> next cycle out_data=4'b1001, out_valid=1.
- Streaming 8 beats with out_ready=1 -> 8 consecutive out_valid cycles, in_ready constantly 1, latency 1.
- Hold out_ready=0 for 3 cycles with beat pending -> in_ready=0, out_data stable; release -> beat consumed, next beat accepted same cycle.
- cfg_start with beat held and out_ready=0 -> DRAIN, in_ready=0; out_ready=1 -> CONFIG next cycle; cfg_we in RUN/DRAIN leaves table unchanged.
- With LUT_STATUS_EN: 5 accepted beats -> lookup_count=5; reconfigure -> 0; 65540 beats -> 16'hFFFF.
